// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: funct codes,
// shift-stage control codes and the sequencer FSM states.
package shift_pkg;

  localparam logic [1:0] FN_SLL = 2'b00;
  localparam logic [1:0] FN_SRL = 2'b01;
  localparam logic [1:0] FN_SRA = 2'b11;

  typedef enum logic [1:0] {
    CTL_HOLD = 2'b00,
    CTL_LOAD = 2'b01,
    CTL_SHL  = 2'b10,
    CTL_SHR  = 2'b11
  } ctl_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Right shifts for SRL/SRA; the reserved code falls through to a left shift.
  function automatic ctl_e shift_ctl(input logic [1:0] fn);
    return ((fn == FN_SRL) || (fn == FN_SRA)) ? CTL_SHR : CTL_SHL;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// Enable-controlled shift register: hold, parallel load, or a one-bit
// shift left/right with an externally supplied serial-in bit.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  ctl_e             control,
  input  logic             serialIn,
  input  logic [WIDTH-1:0] loadData,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    case (control)
      CTL_LOAD: data_d = loadData;
      CTL_SHL:  data_d = {data_q[WIDTH-2:0], serialIn};
      CTL_SHR:  data_d = {serialIn, data_q[WIDTH-1:1]};
      default:  data_d = data_q;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign dataOut = data_q;

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer that loads one SLL/SRL/SRA request into the shift stage and
// steps it one bit per clock, pulsing done when the result is ready.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         funct,
  input  logic [WIDTH-1:0]   dataIn,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dataOut
);

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [1:0]         funct_q, funct_d;
  logic               msb_q,   msb_d;
  ctl_e               ctl;
  logic               serial_in;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      funct_q <= FN_SLL;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      funct_q <= funct_d;
      msb_q   <= msb_d;
    end
  end

  // The sign bit for SRA is frozen at load so every step shifts in the original MSB.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    funct_d   = funct_q;
    msb_d     = msb_q;
    ctl       = CTL_HOLD;
    serial_in = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ctl     = CTL_LOAD;
          funct_d = funct;
          count_d = shamt;
          msb_d   = dataIn[WIDTH-1];
          state_d = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        ctl       = shift_ctl(funct_q);
        serial_in = (funct_q == FN_SRA) ? msb_q : 1'b0;
        count_d   = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

  shift_stage #(
    .WIDTH(WIDTH)
  ) u_stage (
    .CLK      (CLK),
    .reset    (reset),
    .control  (ctl),
    .serialIn (serial_in),
    .loadData (dataIn),
    .dataOut  (dataOut)
  );

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: table-driven jobs with a
// scoreboard of expected results and done cycles, plus corner sequences.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic        CLK;
  logic        reset;
  logic        start;
  logic [1:0]  funct;
  logic [31:0] dataIn;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [1:0]  funct;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          done_cyc;
  } sb_t;

  sb_t sb[$];

  shift_sequencer #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .CLK     (CLK),
    .reset   (reset),
    .start   (start),
    .funct   (funct),
    .dataIn  (dataIn),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h want=0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Any done pulse must match the oldest outstanding job, in value and cycle.
  always @(negedge CLK) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'h0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        checkOutput("result", dataOut, e.data);
        checkOutput("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] f, input logic [31:0] d,
                               input logic [4:0] s, input logic [31:0] exp_data,
                               output int start_edge);
    sb_t e;
    @(negedge CLK);
    funct      = f;
    dataIn     = d;
    shamt      = s;
    start      = 1'b1;
    start_edge = cyc + 1;
    e.data     = exp_data;
    e.done_cyc = start_edge + int'(s);
    sb.push_back(e);
  endtask

  // Walks the job cycle by cycle checking busy; optionally fires a stray
  // start (SLL 0xFFFFFFFF by 8) at loop step intrude_at, which must be ignored.
  task automatic waitJob(input int s, input int start_edge, input int intrude_at,
                         input logic [31:0] exp_data);
    bit got = 1'b0;
    for (int i = 0; i <= s + 3 && !got; i++) begin
      @(negedge CLK);
      start = 1'b0;
      if (i == intrude_at) begin
        funct  = FN_SLL;
        dataIn = 32'hFFFF_FFFF;
        shamt  = 5'd8;
        start  = 1'b1;
      end
      checkOutput("busy", 32'(busy),
                  32'((s != 0) && (cyc >= start_edge) && (cyc < start_edge + s)));
      #1;
      if (sb.size() == 0) got = 1'b1;
    end
    if (!got) begin
      checkOutput("done_timeout", 32'(got), 32'h1);
      sb.delete();
    end
    @(negedge CLK);
    start = 1'b0;
    checkOutput("done_after", 32'(done), 32'h0);
    checkOutput("hold_after", dataOut, exp_data);
  endtask

  vec_t vecs[10];
  int   se;

  initial begin
    vecs[0] = '{FN_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[1] = '{FN_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[2] = '{FN_SRL, 32'hF000_0000, 5'd28, 32'h0000_000F};
    vecs[3] = '{FN_SRA, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[4] = '{2'b10,  32'h0000_0003, 5'd2,  32'h0000_000C};
    vecs[5] = '{FN_SRA, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF};
    vecs[6] = '{FN_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[7] = '{FN_SRA, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF};
    vecs[8] = '{FN_SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[9] = '{FN_SRA, 32'h8000_0000, 5'd1,  32'hC000_0000};

    reset  = 1'b1;
    start  = 1'b0;
    funct  = FN_SLL;
    dataIn = '0;
    shamt  = '0;
    #2;
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_data", dataOut, 32'h0);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].funct, vecs[i].data, vecs[i].shamt, vecs[i].exp_data, se);
      waitJob(int'(vecs[i].shamt), se, -1, vecs[i].exp_data);
    end

    $display("[TB] start while busy");
    applyStimulus(FN_SRL, 32'hF000_0000, 5'd28, 32'h0000_000F, se);
    waitJob(28, se, 5, 32'h0000_000F);
    repeat (12) @(negedge CLK);
    checkOutput("ignored_hold", dataOut, 32'h0000_000F);

    $display("[TB] start in done cycle");
    applyStimulus(FN_SLL, 32'h0000_0003, 5'd1, 32'h0000_0006, se);
    waitJob(1, se, 1, 32'h0000_0006);
    repeat (12) @(negedge CLK);
    checkOutput("done_start_busy", 32'(busy), 32'h0);
    checkOutput("done_start_hold", dataOut, 32'h0000_0006);

    $display("[TB] reset mid-shift");
    applyStimulus(FN_SLL, 32'h0000_0001, 5'd10, 32'h0000_0400, se);
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    checkOutput("abort_data", dataOut, 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_done", 32'(done), 32'h0);
    @(negedge CLK);
    reset = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      checkOutput("abort_idle_busy", 32'(busy), 32'h0);
    end
    applyStimulus(FN_SRL, 32'h0000_0100, 5'd8, 32'h0000_0001, se);
    waitJob(8, se, -1, 32'h0000_0001);

    $display("[TB] reset with start");
    @(negedge CLK);
    reset  = 1'b1;
    start  = 1'b1;
    funct  = FN_SLL;
    dataIn = 32'hFFFF_FFFF;
    shamt  = 5'd3;
    @(negedge CLK);
    reset = 1'b0;
    start = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      checkOutput("rst_start_busy", 32'(busy), 32'h0);
    end
    checkOutput("rst_start_data", dataOut, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit for the MIPS datapath. It sits directly upstream of the enable-controlled shift register stage and drives it. It accepts one shift request (SLL/SRL/SRA) with a 5-bit shift amount, then steps the shift register one bit per clock with the correct serial-in bit. It returns the result with a one-cycle `done` pulse, so the ALU result mux can take it over a start/busy/done handshake.

## Interface
- `WIDTH`, default 32: data width.
- `SHAMT_W`, default 5: shift-amount width. Must satisfy 2^SHAMT_W = WIDTH.

- `CLK` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request strobe. Sampled only when `busy` = 0.
- `funct` in 2: 00 = SLL, 01 = SRL, 11 = SRA, 10 = reserved (executes as SLL).
- `dataIn` in WIDTH: operand, captured with `start`.
- `shamt` in SHAMT_W: shift amount 0..WIDTH-1, captured with `start`.
- `busy` out 1: high from the cycle after `start` is accepted until `done` has been asserted.
- `done` out 1: one-cycle pulse; `dataOut` is valid in that cycle.
- `dataOut` out WIDTH: result register. Holds its value until the next accepted `start`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `start` = 1: load `dataIn` into the shift stage (control = LOAD), latch `funct`, and set count = `shamt`.
  - Next state is SHIFT if `shamt` ≠ 0, otherwise DONE.
- **SHIFT**, once per cycle:
  - SLL: control = SHL, serial-in = 0.
  - SRL: control = SHR, serial-in = 0.
  - SRA: control = SHR, serial-in = current MSB, captured at load and held constant.
  - Decrement count. When count = 1 before the decrement, the next state is DONE.
- **DONE**: `done` = 1, control = HOLD, next state IDLE. `busy` is low in DONE.
- `start` while `busy` = 1 is ignored. It is not queued.
- `start` in the DONE cycle is ignored. Requests are accepted in IDLE only.
- Count is SHAMT_W bits wide and never wraps. A decrement from 0 cannot occur.
- `dataOut` is the shift-stage register itself. In SHIFT it shows intermediate values; consumers must qualify it with `done`.

## Timing
- Reset (asynchronous, takes effect immediately): state = IDLE, count = 0, `busy` = 0, `done` = 0, `dataOut` = 0, latched funct = SLL.
- Latency: `start` sampled at edge E0 gives `done` high in the cycle after edge E(shamt).
  - Total latency is shamt + 1 cycles.
  - Example: `shamt` = 0 gives `done` in the cycle immediately after E0.
- `busy` rises in the cycle after E0 when `shamt` ≠ 0 and falls at the edge that enters DONE.
- When `shamt` = 0, `busy` never rises; `done` pulses one cycle after E0.
- Back-to-back throughput: the next `start` is accepted at the earliest in the cycle after DONE.
- Reset asserted mid-SHIFT aborts the operation: no `done` pulse and `dataOut` = 0. After release the block is in IDLE.
- `reset` and `start` asserted together: reset wins and the request is dropped.

## Structure
- Shared package `shift_pkg`:
  - funct encodings: FN_SLL, FN_SRL, FN_SRA.
  - Shift-stage control encodings: CTL_HOLD = 00, CTL_LOAD = 01, CTL_SHL = 10, CTL_SHR = 11.
  - FSM state typedef: IDLE, SHIFT, DONE.
- One sub-module, `shift_stage`: a WIDTH-bit register with async reset and inputs control[1:0], serialIn, loadData.
  - It implements hold, load, shift-left-1 and shift-right-1.
- `shift_sequencer` contains the FSM, the count and the serial-in selection, and instantiates `shift_stage`.

## Test plan
- SRA, `dataIn` = 0x80000000, `shamt` = 4, start at cycle 0 → `dataOut` = 0xF8000000, `done` in cycle 5 only, `busy` high in cycles 1–4.
- SLL, 0x00000001, `shamt` = 31 → 0x80000000, `done` in cycle 32. SRL, 0xF0000000, `shamt` = 28 → 0x0000000F.
- `shamt` = 0, SRA, 0x12345678 → `done` in cycle 1 with 0x12345678; `busy` never asserted.
- Second `start` (SLL, 0xFFFFFFFF, 8) issued while busy on the SRL-by-28 job → ignored; the result is still 0x0000000F and exactly one `done` pulse occurs.
- Reset pulse at cycle 3 of an SLL-by-10 → `dataOut` = 0 and `busy` = 0 immediately; no `done`. A fresh SRL of 0x100 by 8 afterwards → 0x1.
- Reserved funct 10, 0x3, `shamt` = 2 → 0xC (executes as SLL).
